router_ingress_parser: RTL and testbench

Upstream framing stage for the 4-port router. It accepts a byte stream of framed packets (header, payload, checksum) and extracts the 2-bit destination from the header. It forwards each payload beat to the router's din/addr/valid_in/ready_out interface, holding addr constant for the whole packet. It checks an XOR checksum and reports packet completion and errors.

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_out_reg.sv | 51 +++++
 rtl/router_ingress_parser.sv | 130 +++++++++++++
 tb/tb_router_ingress_parser.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants and types for the 4-port router and its ingress parser.
//   DEF_DATA_WIDTH / DEF_LEN_W : default beat width and header length width
//   ADDR_HI / ADDR_LO          : destination field position in the header
//   NUM_PORTS / ADDR_W         : router port count and destination width
//   state_e                    : ingress parser FSM states
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_W      = 6;

  localparam int ADDR_HI = 7;
  localparam int ADDR_LO = 6;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAY,
    S_CHK
  } state_e;

endpackage

// File: rtl/router_out_reg.sv
// ---------------------------------------------------------------------------
// router_out_reg
// One-entry valid/ready output register in front of the router din/addr port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load, load_din        write a payload beat into the slot (only when ready)
//   addr_load, addr_in    update the destination (header acceptance only)
//   out_ready             downstream ready
//   out_valid/out_din/out_addr  registered outputs to the router
//   ready                 slot can take a beat this cycle
// ---------------------------------------------------------------------------
module router_out_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_din,
  input  logic                  addr_load,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  ready
);

  // Slot frees up in the same cycle the held beat is taken downstream.
  assign ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_din   <= '0;
      out_addr  <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_din   <= load_din;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (addr_load) begin
        out_addr <= addr_in;
      end
    end
  end

endmodule

// File: rtl/router_ingress_parser.sv
// ---------------------------------------------------------------------------
// router_ingress_parser
// Parses a framed byte stream (header, payload, XOR checksum) and forwards
// payload beats to the router with the header's destination held on out_addr.
//
// state | meaning
// S_HDR | waiting for a header beat (destination + payload length)
// S_PAY | forwarding payload beats, counter holds beats still to come
// S_CHK | waiting for the checksum beat, compared against running XOR
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data/in_valid/in_ready   framed input stream
//   out_din/out_addr/out_valid/out_ready   router din/addr/valid_in/ready_out
//   pkt_done            one-cycle pulse after the checksum beat is consumed
//   chk_err             pulses with pkt_done when the checksum mismatched
//   busy                high from header acceptance until pkt_done
// ---------------------------------------------------------------------------
module router_ingress_parser
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  pkt_done,
  output logic                  chk_err,
  output logic                  busy
);

  state_e                state;
  logic [LEN_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic                  slot_ready;
  logic                  in_fire;
  logic                  hdr_fire;
  logic                  pay_fire;
  logic                  chk_fire;
  logic [LEN_W-1:0]      hdr_len;
  logic [ADDR_W-1:0]     hdr_addr;

  assign hdr_len  = in_data[LEN_W-1:0];
  assign hdr_addr = in_data[ADDR_HI:ADDR_LO];

  // A header must also wait for the slot: changing out_addr under a pending
  // beat would misroute it.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_HDR:   in_ready = slot_ready;
      S_PAY:   in_ready = slot_ready;
      S_CHK:   in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign hdr_fire = in_fire && (state == S_HDR);
  assign pay_fire = in_fire && (state == S_PAY);
  assign chk_fire = in_fire && (state == S_CHK);

  router_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pay_fire),
    .load_din (in_data),
    .addr_load(hdr_fire),
    .addr_in  (hdr_addr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_din  (out_din),
    .out_addr (out_addr),
    .ready    (slot_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_HDR;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      chk_err  <= 1'b0;
      case (state)
        S_HDR: begin
          if (hdr_fire) begin
            cnt   <= hdr_len;
            acc   <= '0;
            busy  <= 1'b1;
            state <= (hdr_len != '0) ? S_PAY : S_CHK;
          end
        end
        S_PAY: begin
          if (pay_fire) begin
            acc <= acc ^ in_data;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end
            if (cnt == LEN_W'(1)) begin
              state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (chk_fire) begin
            pkt_done <= 1'b1;
            chk_err  <= (in_data != acc);
            busy     <= 1'b0;
            state    <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_router_ingress_parser.sv
// ---------------------------------------------------------------------------
// tb_router_ingress_parser
// Directed and randomized packets against a packet-level reference: each
// packet is described by destination, payload list and checksum byte; the
// expected router traffic is the payload list tagged with the destination,
// and the expected error flag is (checksum != XOR of payload).
// ---------------------------------------------------------------------------
module tb_router_ingress_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_din;
  logic [1:0] out_addr;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       pkt_done;
  logic       chk_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int cyc      = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    int         cyc;
  } beat_t;

  beat_t      obs_beats[$];
  beat_t      exp_beats[$];
  logic       obs_done[$];
  logic       exp_done[$];
  logic [7:0] pay[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_din = '0;
  logic [1:0] prev_addr = '0;

  router_ingress_parser dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_din  (out_din),
    .out_addr (out_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_done (pkt_done),
    .chk_err  (chk_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // out_ready changes shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: records router transfers and completions, checks hold-stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_din", 32'(out_din), 32'(prev_din));
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
      end
      if (out_valid && out_ready) begin
        beat_t b;
        b.addr = out_addr;
        b.din  = out_din;
        b.cyc  = cyc;
        obs_beats.push_back(b);
      end
      if (pkt_done) obs_done.push_back(chk_err);
      if (chk_err) chk("err_with_done", 32'(pkt_done), 32'd1);
      prev_stall = out_valid && !out_ready;
      prev_din   = out_din;
      prev_addr  = out_addr;
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic add_exp(input logic [1:0] a, input logic [7:0] ck, output logic err);
    logic [7:0] x;
    beat_t      b;
    x = '0;
    foreach (pay[i]) begin
      x      ^= pay[i];
      b.addr = a;
      b.din  = pay[i];
      b.cyc  = 0;
      exp_beats.push_back(b);
    end
    err = (ck != x);
    exp_done.push_back(err);
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [7:0] ck, input bit b2b);
    logic err;
    add_exp(a, ck, err);
    send({a, 6'(pay.size())});
    #1 chk("busy_after_hdr", 32'(busy), 32'd1);
    foreach (pay[i]) send(pay[i]);
    send(ck);
    #1;
    chk("pkt_done", 32'(pkt_done), 32'd1);
    chk("chk_err", 32'(chk_err), 32'(err));
    chk("busy_clear", 32'(busy), 32'd0);
    if (!b2b) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic flush(input string tag);
    int n = 0;
    while ((obs_beats.size() < exp_beats.size() || obs_done.size() < exp_done.size()
            || out_valid) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_nbeats"}, 32'(obs_beats.size()), 32'(exp_beats.size()));
    chk({tag, "_ndone"}, 32'(obs_done.size()), 32'(exp_done.size()));
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
      chk({tag, "_addr"}, 32'(obs_beats[i].addr), 32'(exp_beats[i].addr));
      chk({tag, "_din"}, 32'(obs_beats[i].din), 32'(exp_beats[i].din));
    end
    for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
      chk({tag, "_err"}, 32'(obs_done[i]), 32'(exp_done[i]));
    end
    obs_beats.delete();
    exp_beats.delete();
    obs_done.delete();
    exp_done.delete();
  endtask

  initial begin
    logic       e;
    logic [7:0] x;
    logic [1:0] a;
    int         len;
    bit         b2b;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_din", 32'(out_din), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic packet: 83, 11, 22, 33, 00
    pay = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd2, 8'h00, 1'b0);
    flush("basic");

    // Backpressure: C2, A5, 5A, FF with out_ready low after the first beat
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    pay = '{8'hA5, 8'h5A};
    add_exp(2'd3, 8'hFF, e);
    send(8'hC2);
    send(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_din", 32'(out_din), 32'hA5);
      chk("bp_addr", 32'(out_addr), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 1;
    send(8'h5A);
    send(8'hFF);
    #1;
    chk("bp_pkt_done", 32'(pkt_done), 32'd1);
    chk("bp_chk_err", 32'(chk_err), 32'(e));
    @(negedge clk);
    in_valid = 1'b0;
    flush("bp");

    // Zero length, good then bad checksum
    pay.delete();
    send_pkt(2'd1, 8'h00, 1'b0);
    send_pkt(2'd1, 8'h01, 1'b0);
    flush("zero");

    // Checksum error: 01, 3C, 3D
    pay = '{8'h3C};
    send_pkt(2'd0, 8'h3D, 1'b0);
    flush("cksum");

    // Back-to-back packets to addr 1 then addr 2
    pay = '{8'h10, 8'h20, 8'h30};
    send_pkt(2'd1, 8'h00, 1'b1);
    pay = '{8'h44, 8'h55, 8'h66, 8'h77};
    send_pkt(2'd2, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    for (int i = 1; i < obs_beats.size(); i++) begin
      if (obs_beats[i].addr == obs_beats[i-1].addr)
        chk("b2b_no_bubble", 32'(obs_beats[i].cyc - obs_beats[i-1].cyc), 32'd1);
    end
    flush("b2b");

    // Reset after the second payload beat of a length-5 packet
    send(8'hC5);
    send(8'h01);
    send(8'h02);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_pkt_done", 32'(pkt_done), 32'd0);
    chk("mrst_out_din", 32'(out_din), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("mrst_no_done", 32'(obs_done.size()), 32'd0);
    obs_beats.delete();
    obs_done.delete();
    pay = '{8'h9A, 8'hBC, 8'hDE};
    send_pkt(2'd2, 8'h9A ^ 8'hBC ^ 8'hDE, 1'b0);
    flush("post_rst");

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      rdy_mode = int'($urandom_range(1, 2));
      a   = 2'($urandom);
      len = int'($urandom_range(0, 8));
      pay.delete();
      x = '0;
      for (int i = 0; i < len; i++) begin
        pay.push_back(8'($urandom));
        x ^= pay[i];
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      b2b = (p != 39) && ($urandom_range(0, 1) == 1);
      send_pkt(a, x, b2b);
      if (!b2b) flush("rand");
    end
    rdy_mode = 1;
    flush("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
